// File: rtl/rs_switch_conditioner_if.sv
// Switch-side bundle of rs_switch_conditioner: raw switch inputs in, clean levels and pulses out.
// master = switch board / bench, slave = conditioner.
interface rs_switch_conditioner_if;
    logic       sw3_CLK_raw;
    logic       sw2_R_raw;
    logic       sw1_S_raw;
    logic       clk_lvl;
    logic       r_lvl;
    logic       s_lvl;
    logic [2:0] rise_pulse;
    logic [2:0] fall_pulse;
    logic       led_forbidden;

    modport master (
        output sw3_CLK_raw, sw2_R_raw, sw1_S_raw,
        input  clk_lvl, r_lvl, s_lvl, rise_pulse, fall_pulse, led_forbidden
    );

    modport slave (
        input  sw3_CLK_raw, sw2_R_raw, sw1_S_raw,
        output clk_lvl, r_lvl, s_lvl, rise_pulse, fall_pulse, led_forbidden
    );
endinterface

// File: rtl/rs_switch_conditioner.sv
// Synchronizes and debounces the three RS-latch switches (CLK, R, S) into clean levels and edge pulses.
// Optional macro RS_FORBIDDEN_DETECT_EN enables the registered forbidden-combination LED.
module rs_switch_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input logic                    clk,
    input logic                    reset,
    rs_switch_conditioner_if.slave sw
);
    typedef enum logic [1:0] {StLow, StToHigh, StHigh, StToLow} state_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    // Channel order everywhere: [2]=CLK, [1]=R, [0]=S.
    logic [2:0]           raw;
    logic [2:0]           sync1_q, sync2_q;
    state_e               state_q [3];
    state_e               state_d [3];
    logic [CNT_WIDTH-1:0] cnt_q   [3];
    logic [CNT_WIDTH-1:0] cnt_d   [3];
    logic [2:0]           level_q, level_d;
    logic [2:0]           rise_q, rise_d;
    logic [2:0]           fall_q, fall_d;

    assign raw = {sw.sw3_CLK_raw, sw.sw2_R_raw, sw.sw1_S_raw};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            rise_d[i]  = 1'b0;
            fall_d[i]  = 1'b0;
            unique case (state_q[i])
                StLow: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StToHigh;
                        cnt_d[i]   = CntOne;
                    end
                end
                StToHigh: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StLow;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StHigh;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StHigh: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = StToLow;
                        cnt_d[i]   = CntOne;
                    end
                end
                StToLow: begin
                    if (sync2_q[i]) begin
                        state_d[i] = StHigh;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StLow;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StLow;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StLow;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

`ifdef RS_FORBIDDEN_DETECT_EN
    // All three high drives both NAND-latch outputs high: flag it one cycle later.
    logic forbidden_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            forbidden_q <= 1'b0;
        end else begin
            forbidden_q <= &level_q;
        end
    end

    assign sw.led_forbidden = forbidden_q;
`else
    assign sw.led_forbidden = 1'b0;
`endif

    assign sw.clk_lvl    = level_q[2];
    assign sw.r_lvl      = level_q[1];
    assign sw.s_lvl      = level_q[0];
    assign sw.rise_pulse = rise_q;
    assign sw.fall_pulse = fall_q;
endmodule

// File: tb/tb_rs_switch_conditioner.sv
// Directed bench for rs_switch_conditioner with DEBOUNCE_CYCLES=4 (level follows 6 edges after sampling).
// Expected LED value depends on whether RS_FORBIDDEN_DETECT_EN is defined for the build.
module tb_rs_switch_conditioner;
`ifdef RS_FORBIDDEN_DETECT_EN
    localparam bit Forb = 1'b1;
`else
    localparam bit Forb = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] lvl_prev = 3'b000;

    rs_switch_conditioner_if bus ();

    rs_switch_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] raw;
        logic [2:0] lvl;
        logic [2:0] rise;
        logic [2:0] fall;
    } vec_t;

    vec_t vecs [18];

    // Drive one cycle of inputs, clock once, compare #1 after the edge.
    task automatic cycle(input string name, input logic r, input logic [2:0] raw,
                         input logic [2:0] lvl, input logic [2:0] rise, input logic [2:0] fall);
        logic [9:0] got, exp;
        logic       led_exp;
        reset           = r;
        bus.sw3_CLK_raw = raw[2];
        bus.sw2_R_raw   = raw[1];
        bus.sw1_S_raw   = raw[0];
        @(posedge clk);
        #1;
        led_exp = Forb && !r && (&lvl_prev);
        exp = {lvl, rise, fall, led_exp};
        got = {bus.clk_lvl, bus.r_lvl, bus.s_lvl, bus.rise_pulse, bus.fall_pulse,
               bus.led_forbidden};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got lvl/rise/fall/led=%b_%b_%b_%b expected %b_%b_%b_%b",
                     name, got[9:7], got[6:4], got[3:1], got[0],
                     exp[9:7], exp[6:4], exp[3:1], exp[0]);
        end
        lvl_prev = lvl;
    endtask

    initial begin
        reset           = 1'b1;
        bus.sw3_CLK_raw = 1'b0;
        bus.sw2_R_raw   = 1'b0;
        bus.sw1_S_raw   = 1'b0;

        // Reset with all switches up, release, all rise together, then drop R.
        for (int i = 0; i < 3; i++)  vecs[i] = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000};
        for (int i = 3; i < 8; i++)  vecs[i] = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000};
        vecs[8] = '{1'b0, 3'b111, 3'b111, 3'b111, 3'b000};
        vecs[9] = '{1'b0, 3'b111, 3'b111, 3'b000, 3'b000};
        vecs[10] = '{1'b0, 3'b111, 3'b111, 3'b000, 3'b000};
        for (int i = 11; i < 16; i++) vecs[i] = '{1'b0, 3'b101, 3'b111, 3'b000, 3'b000};
        vecs[16] = '{1'b0, 3'b101, 3'b101, 3'b000, 3'b010};
        vecs[17] = '{1'b0, 3'b101, 3'b101, 3'b000, 3'b000};

        for (int i = 0; i < 18; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].raw, vecs[i].lvl,
                  vecs[i].rise, vecs[i].fall);
        end

        // Bounce on S: 2-cycle toggles rejected, then a clean rise 6 edges after the final 1.
        cycle("bounce_rst", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int t = 0; t < 8; t++) begin
            cycle("bounce_toggle", 1'b0, {2'b00, ~t[1]}, 3'b000, 3'b000, 3'b000);
        end
        for (int t = 1; t <= 8; t++) begin
            cycle("bounce_settle", 1'b0, 3'b001, (t >= 6) ? 3'b001 : 3'b000,
                  (t == 6) ? 3'b001 : 3'b000, 3'b000);
        end

        // Threshold: 3-cycle R pulse ignored; 4-cycle pulse rises at edge 6 and falls at edge 10.
        cycle("thr_rst", 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int t = 1; t <= 10; t++) begin
            cycle("thr_short", 1'b0, (t <= 3) ? 3'b010 : 3'b000, 3'b000, 3'b000, 3'b000);
        end
        for (int t = 1; t <= 12; t++) begin
            cycle("thr_long", 1'b0, (t <= 4) ? 3'b010 : 3'b000,
                  (t >= 6 && t < 10) ? 3'b010 : 3'b000,
                  (t == 6) ? 3'b010 : 3'b000, (t == 10) ? 3'b010 : 3'b000);
        end

        // Reset at edge 4 of a CLK debounce restarts qualification from zero.
        for (int t = 1; t <= 12; t++) begin
            cycle("mid_rst", (t == 4), 3'b100, (t >= 10) ? 3'b100 : 3'b000,
                  (t == 10) ? 3'b100 : 3'b000, 3'b000);
        end

        // Forbidden: R and S join CLK high, then S drops.
        for (int t = 1; t <= 8; t++) begin
            cycle("forb_up", 1'b0, 3'b111, (t >= 6) ? 3'b111 : 3'b100,
                  (t == 6) ? 3'b011 : 3'b000, 3'b000);
        end
        for (int t = 1; t <= 8; t++) begin
            cycle("forb_down", 1'b0, 3'b110, (t >= 6) ? 3'b110 : 3'b111, 3'b000,
                  (t == 6) ? 3'b001 : 3'b000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_switch_conditioner.md
Name: rs_switch_conditioner

Overview:
- Input conditioning stage placed directly upstream of the level-triggered RS latch on the experiment board.
- Takes three raw, bouncy slide-switch inputs (latch enable, R, S) and passes each through a 2-FF synchronizer and a per-channel debounce FSM.
- Outputs clean level signals that drive the latch's CLK/R/S inputs, one-cycle rise/fall pulses for each channel, and a status LED.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive clk edges a synchronized input must hold a new value before the clean level follows it; legal range 2..65535.
- CNT_WIDTH, 16, width of each per-channel debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock (board oscillator).
- reset  input  1  synchronous, active-high reset.
- sw3_CLK_raw  input  1  raw latch-enable switch, asynchronous to clk.
- sw2_R_raw  input  1  raw reset switch, asynchronous to clk.
- sw1_S_raw  input  1  raw set switch, asynchronous to clk.
- clk_lvl  output  1  debounced latch enable; feeds the latch CLK input.
- r_lvl  output  1  debounced R.
- s_lvl  output  1  debounced S.
- rise_pulse  output  3  one-cycle pulse on each 0->1 of the clean level; bit order [2]=CLK, [1]=R, [0]=S.
- fall_pulse  output  3  one-cycle pulse on each 1->0 of the clean level; same bit order.
- led_forbidden  output  1  forbidden-input indicator; see Optional Feature.

Behaviour:
- Reset is the only reset. It is synchronous and active-high, sampled on the rising edge of clk. While reset=1 on an edge:
  - all synchronizer flops, clean levels, counters, pulses and led_forbidden go to 0;
  - every FSM goes to LOW.
- Reset may be asserted mid-debounce. The count in progress is discarded. After reset deasserts, a raw input held at 1 is re-qualified from zero and needs the full latency again.
- Synchronizer: two flops per channel, sync1 <= raw, sync2 <= sync1. Only sync2 is used downstream.
- Per-channel FSM has four states: LOW, TO_HIGH, HIGH, TO_LOW.
  - LOW: level=0. If sync2=1, go to TO_HIGH with cnt=1.
  - TO_HIGH: level=0.
    - If sync2=0, go to LOW and clear cnt (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to HIGH, set level=1, clear cnt, and assert rise_pulse for exactly one cycle.
    - Else increment cnt.
  - HIGH and TO_LOW mirror LOW and TO_HIGH with polarity inverted; fall_pulse is asserted on entry to LOW.
- Latency: a clean raw transition held steady appears on the level output DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
- Glitch rejection: any pulse shorter than DEBOUNCE_CYCLES clk periods after synchronization never reaches the outputs.
- Pulses are registered. Each pulse is high in the same cycle the corresponding level first shows its new value, and low in all other cycles.
- Channels are fully independent. Simultaneous transitions on several switches produce simultaneous pulses on the corresponding bits.
- The counter never wraps: it is cleared on every state change and saturates by construction at DEBOUNCE_CYCLES-1.
- All outputs are registered. No combinational path runs from any raw input to any output.

Optional Feature:
- Macro: RS_FORBIDDEN_DETECT_EN.
- Defined:
  - led_forbidden is a registered signal, asserted one cycle after clk_lvl & r_lvl & s_lvl becomes 1. This is the forbidden input combination for the NAND latch.
  - It deasserts one cycle after any of the three levels drops.
  - It is 0 during reset.
- Undefined: led_forbidden is tied to constant 0 and the detection logic is not synthesized.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset: hold reset=1 for 3 cycles with all raw inputs =1 -> all outputs 0 throughout. Release reset and keep raw=1 -> clk_lvl, r_lvl and s_lvl rise 6 edges later, with rise_pulse=3'b111 for exactly one cycle.
- Bounce rejection: toggle sw1_S_raw 1,0,1,0 every 2 cycles, then hold at 1 -> s_lvl stays 0 during the toggling and rises exactly 6 edges after the final stable 1; rise_pulse[0] asserts once.
- Release: with r_lvl=1, drop sw2_R_raw to 0 and hold -> r_lvl falls 6 edges later; fall_pulse[1] is one cycle wide; the other pulse bits stay 0.
- Threshold boundary: a raw high pulse lasting 3 clk cycles -> no output change. A pulse lasting 4 cycles, then low -> r_lvl rises, then falls after 6 further edges.
- Reset mid-debounce: raise sw3_CLK_raw, assert reset for 1 cycle at edge 4 -> clk_lvl=0, and the rise occurs only 6 edges after reset deasserts.
- Forbidden detection (macro defined): debounce all three to 1 -> led_forbidden=1 one cycle after the last level rises. Drop S -> led_forbidden=0 one cycle after s_lvl falls. With the macro undefined -> led_forbidden stays 0.
